// File: rtl/demux4_buf.sv
// demux4_buf: 1-to-4 valid/ready stream demultiplexer with one small FIFO per sink.
// A stalled sink only blocks beats addressed to it.
// Optional build macro: DEMUX4_STATS_EN adds stat_cnt, a per-sink count of popped beats.
module demux4_buf #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 2
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [1:0]         in_sel,
   input  logic [WIDTH-1:0]   in_data,
   output logic [3:0]         out_valid,
   input  logic [3:0]         out_ready,
   output logic [4*WIDTH-1:0] out_data,
   output logic               busy
`ifdef DEMUX4_STATS_EN
   ,
   output logic [4*32-1:0]    stat_cnt
`endif
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef logic [AW:0] ptr_t;

   ptr_t             wptr_q [4];
   ptr_t             wptr_d [4];
   ptr_t             rptr_q [4];
   ptr_t             rptr_d [4];
   logic [WIDTH-1:0] mem_q  [4][DEPTH];

   logic [3:0] empty;
   logic [3:0] full;
   logic [3:0] push;
   logic [3:0] pop;

   // FIFO status from the registered pointers only.
   // in_ready therefore never depends on out_ready.
   always_comb begin
      empty = '0;
      full  = '0;
      for (int unsigned k = 0; k < 4; k++) begin
         empty[k] = (wptr_q[k] == rptr_q[k]);
         full[k]  = (wptr_q[k][AW] != rptr_q[k][AW]) &&
                    (wptr_q[k][AW-1:0] == rptr_q[k][AW-1:0]);
      end
   end

   // Handshake decode and sink-side outputs.
   // Each head entry is read straight from storage, so there is no same-cycle bypass.
   always_comb begin
      in_ready  = ~full[in_sel];
      push      = '0;
      if (in_valid && in_ready) begin
         push[in_sel] = 1'b1;
      end
      out_valid = ~empty;
      pop       = out_valid & out_ready;
      busy      = |(~empty);
      out_data  = '0;
      for (int unsigned k = 0; k < 4; k++) begin
         out_data[k*WIDTH +: WIDTH] = mem_q[k][rptr_q[k][AW-1:0]];
      end
   end

   // Next-state pointers.
   // Both pointers wrap naturally modulo 2*DEPTH.
   always_comb begin
      for (int unsigned k = 0; k < 4; k++) begin
         wptr_d[k] = wptr_q[k] + ptr_t'(push[k]);
         rptr_d[k] = rptr_q[k] + ptr_t'(pop[k]);
      end
   end

   // Pointer and storage registers.
   // Reset discards all buffered beats and zeroes storage, so out_data reads 0.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int unsigned k = 0; k < 4; k++) begin
            wptr_q[k] <= '0;
            rptr_q[k] <= '0;
            for (int unsigned e = 0; e < DEPTH; e++) begin
               mem_q[k][e] <= '0;
            end
         end
      end else begin
         for (int unsigned k = 0; k < 4; k++) begin
            wptr_q[k] <= wptr_d[k];
            rptr_q[k] <= rptr_d[k];
            if (push[k]) begin
               mem_q[k][wptr_q[k][AW-1:0]] <= in_data;
            end
         end
      end
   end

`ifdef DEMUX4_STATS_EN
   logic [31:0] stat_q [4];

   // Per-sink pop counters.
   // Each counter wraps modulo 2^32 and is updated on the edge that ends the pop cycle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int unsigned k = 0; k < 4; k++) begin
            stat_q[k] <= '0;
         end
      end else begin
         for (int unsigned k = 0; k < 4; k++) begin
            stat_q[k] <= stat_q[k] + 32'(pop[k]);
         end
      end
   end

   // Pack the counters onto the stat_cnt port.
   always_comb begin
      stat_cnt = '0;
      for (int unsigned k = 0; k < 4; k++) begin
         stat_cnt[k*32 +: 32] = stat_q[k];
      end
   end
`endif

endmodule

// File: tb/tb_demux4_buf.sv
// Directed self-checking bench for demux4_buf (WIDTH=32, DEPTH=2).
module tb_demux4_buf;

   logic         clk;
   logic         resetn;
   logic         in_valid;
   logic         in_ready;
   logic [1:0]   in_sel;
   logic [31:0]  in_data;
   logic [3:0]   out_valid;
   logic [3:0]   out_ready;
   logic [127:0] out_data;
   logic         busy;
`ifdef DEMUX4_STATS_EN
   logic [127:0] stat_cnt;
`endif

   int vectors     = 0;
   int miscompares = 0;

   demux4_buf #(.WIDTH(32), .DEPTH(2)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sel    (in_sel),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
`ifdef DEMUX4_STATS_EN
      ,
      .stat_cnt  (stat_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1);
   end

   function automatic logic [31:0] sink_data(input int k);
      return out_data[k*32 +: 32];
   endfunction

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      resetn    = 1'b0;
      in_valid  = 1'b1;
      in_sel    = 2'd0;
      in_data   = 32'hDEAD_BEEF;
      out_ready = 4'b0000;
      repeat (3) tick();
      vectors++;
      if (out_valid !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_out_valid: got %b, required 0000", out_valid);
      end
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_busy: got %b, required 0", busy);
      end
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_in_ready: got %b, required 1", in_ready);
      end
      vectors++;
      if (out_data !== 128'd0) begin
         miscompares++;
         $display("FAIL reset_out_data: got %h, required 0", out_data);
      end
      in_valid = 1'b0;
      resetn   = 1'b1;
      tick();
      vectors++;
      if (out_valid !== 4'b0000 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_release: got out_valid=%b busy=%b, required 0000/0", out_valid, busy);
      end
   endtask

   task automatic test_routing();
      out_ready = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1;
         in_sel   = 2'(k);
         in_data  = 32'hA0 + 32'(k);
         #1;
         vectors++;
         if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL route_in_ready[%0d]: got %b, required 1", k, in_ready);
         end
         tick();
         in_valid = 1'b0;
         #1;
         vectors++;
         if (out_valid !== (4'b0001 << k)) begin
            miscompares++;
            $display("FAIL route_valid[%0d]: got %b, required %b", k, out_valid, 4'b0001 << k);
         end
         vectors++;
         if (sink_data(k) !== 32'hA0 + 32'(k)) begin
            miscompares++;
            $display("FAIL route_data[%0d]: got %h, required %h", k, sink_data(k), 32'hA0 + 32'(k));
         end
      end
      tick();
      vectors++;
      if (out_valid !== 4'b0000 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL route_drained: got out_valid=%b busy=%b, required 0000/0", out_valid, busy);
      end
   endtask

   task automatic test_backpressure();
      out_ready = 4'b1011;
      in_valid  = 1'b1;
      in_sel    = 2'd2;
      in_data   = 32'h10;
      tick();
      in_data   = 32'h11;
      tick();
      in_data   = 32'h12;
      #1;
      vectors++;
      if (in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_stall: got in_ready=%b, required 0", in_ready);
      end
      tick();
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 4'b0100 || sink_data(2) !== 32'h10) begin
         miscompares++;
         $display("FAIL bp_hold: got ready=%b valid=%b head=%h, required 0/0100/10",
                  in_ready, out_valid, sink_data(2));
      end
      in_sel  = 2'd1;
      in_data = 32'h20;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL bp_other_ready: got %b, required 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      #1;
      vectors++;
      if (out_valid !== 4'b0110 || sink_data(1) !== 32'h20) begin
         miscompares++;
         $display("FAIL bp_other_deliver: got valid=%b data=%h, required 0110/20", out_valid, sink_data(1));
      end
      tick();
      in_valid  = 1'b1;
      in_sel    = 2'd2;
      in_data   = 32'h12;
      #1;
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 4'b0100) begin
         miscompares++;
         $display("FAIL bp_resend_stall: got ready=%b valid=%b, required 0/0100", in_ready, out_valid);
      end
      out_ready = 4'b1111;
      tick();
      vectors++;
      if (in_ready !== 1'b1 || sink_data(2) !== 32'h11) begin
         miscompares++;
         $display("FAIL bp_drain1: got ready=%b head=%h, required 1/11", in_ready, sink_data(2));
      end
      tick();
      in_valid = 1'b0;
      #1;
      vectors++;
      if (out_valid !== 4'b0100 || sink_data(2) !== 32'h12) begin
         miscompares++;
         $display("FAIL bp_drain2: got valid=%b head=%h, required 0100/12", out_valid, sink_data(2));
      end
      tick();
      vectors++;
      if (out_valid !== 4'b0000 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_empty: got valid=%b busy=%b, required 0000/0", out_valid, busy);
      end
   endtask

   task automatic test_full_pop();
      out_ready = 4'b0000;
      in_valid  = 1'b1;
      in_sel    = 2'd0;
      in_data   = 32'h30;
      tick();
      in_data   = 32'h31;
      tick();
      in_data   = 32'h32;
      out_ready = 4'b0001;
      #1;
      vectors++;
      if (in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL full_pop_ready: got %b, required 0", in_ready);
      end
      tick();
      out_ready = 4'b0000;
      #1;
      vectors++;
      if (in_ready !== 1'b1 || sink_data(0) !== 32'h31) begin
         miscompares++;
         $display("FAIL full_pop_next: got ready=%b head=%h, required 1/31", in_ready, sink_data(0));
      end
      tick();
      in_valid = 1'b0;
      #1;
      vectors++;
      if (in_ready !== 1'b0 || sink_data(0) !== 32'h31 || out_valid !== 4'b0001) begin
         miscompares++;
         $display("FAIL full_pop_occ2: got ready=%b head=%h valid=%b, required 0/31/0001",
                  in_ready, sink_data(0), out_valid);
      end
      out_ready = 4'b0001;
      tick();
      vectors++;
      if (sink_data(0) !== 32'h32 || out_valid !== 4'b0001) begin
         miscompares++;
         $display("FAIL full_pop_order: got head=%h valid=%b, required 32/0001", sink_data(0), out_valid);
      end
      tick();
      vectors++;
      if (out_valid !== 4'b0000) begin
         miscompares++;
         $display("FAIL full_pop_empty: got %b, required 0000", out_valid);
      end
      out_ready = 4'b0000;
   endtask

   task automatic test_wrap();
      int sent = 0;
      int rx   = 0;
      int occ  = 0;
      int cyc  = 0;
      logic [31:0] exp_q[$];
      logic        acc;
      logic        deq;
      in_sel = 2'd3;
      while ((rx < 10) && (cyc < 60)) begin
         in_valid     = (sent < 10);
         in_data      = 32'(sent);
         out_ready    = 4'b0000;
         out_ready[3] = ((cyc % 2) == 0);
         #1;
         vectors++;
         if (in_ready !== (occ < 2) || out_valid[3] !== (occ > 0)) begin
            miscompares++;
            $display("FAIL wrap_status cyc%0d: got ready=%b valid=%b, required %b/%b",
                     cyc, in_ready, out_valid[3], occ < 2, occ > 0);
         end
         acc = in_valid && (occ < 2);
         deq = (occ > 0) && out_ready[3];
         if (deq) begin
            vectors++;
            if (sink_data(3) !== exp_q[0]) begin
               miscompares++;
               $display("FAIL wrap_data beat%0d: got %h, required %h", rx, sink_data(3), exp_q[0]);
            end
            void'(exp_q.pop_front());
            rx++;
            occ--;
         end
         if (acc) begin
            exp_q.push_back(32'(sent));
            sent++;
            occ++;
         end
         tick();
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 4'b0000;
      #1;
      vectors++;
      if (rx != 10 || out_valid !== 4'b0000) begin
         miscompares++;
         $display("FAIL wrap_complete: got %0d beats valid=%b, required 10 beats valid=0000", rx, out_valid);
      end
   endtask

   task automatic test_mid_reset();
`ifdef DEMUX4_STATS_EN
      vectors++;
      if (stat_cnt !== {32'd11, 32'd4, 32'd2, 32'd4}) begin
         miscompares++;
         $display("FAIL stats_counts: got %h, required %h", stat_cnt, {32'd11, 32'd4, 32'd2, 32'd4});
      end
`endif
      out_ready = 4'b0000;
      in_valid  = 1'b1;
      in_sel    = 2'd0;
      in_data   = 32'h40;
      tick();
      in_data   = 32'h41;
      tick();
      in_sel    = 2'd1;
      in_data   = 32'h50;
      tick();
      in_valid  = 1'b0;
      #1;
      vectors++;
      if (out_valid !== 4'b0011 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_pre: got valid=%b busy=%b, required 0011/1", out_valid, busy);
      end
      resetn = 1'b0;
      #1;
      vectors++;
      if (out_valid !== 4'b0000 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_async: got valid=%b busy=%b, required 0000/0", out_valid, busy);
      end
      tick();
      resetn = 1'b1;
      tick();
      vectors++;
      if (out_valid !== 4'b0000 || busy !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_after: got valid=%b busy=%b ready=%b, required 0000/0/1",
                  out_valid, busy, in_ready);
      end
`ifdef DEMUX4_STATS_EN
      vectors++;
      if (stat_cnt !== 128'd0) begin
         miscompares++;
         $display("FAIL stats_reset: got %h, required 0", stat_cnt);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_routing();
      test_backpressure();
      test_full_pop();
      test_wrap();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/demux4_buf.md
Name: demux4_buf

Overview:
- 1-to-4 stream demultiplexer: routes one valid/ready source stream to one of four sink channels, chosen by a per-beat 2-bit select.
- Each sink has its own small FIFO, so a stalled sink blocks only beats addressed to it.
- Sits on the CPU side of the bus interface, returning shared-path data (e.g. read data) to instruction-fetch, load and other requesters.

Parameters:
- WIDTH, 32, data bits per beat.
- DEPTH, 2, entries per sink FIFO; power of two, >= 2.

Ports:
- clk  input  1  system clock; all state on rising edge.
- resetn  input  1  asynchronous active-low reset.
- in_valid  input  1  source beat present.
- in_ready  output  1  beat accepted this cycle when in_valid && in_ready.
- in_sel  input  2  destination sink index 0..3; sampled with in_data.
- in_data  input  WIDTH  source payload.
- out_valid  output  4  bit k: sink k head entry valid.
- out_ready  input  4  bit k: sink k consumes head.
- out_data  output  4*WIDTH  sink k payload on bits [k*WIDTH +: WIDTH].
- busy  output  1  any sink FIFO non-empty.

Behaviour:
- Reset (resetn low, async):
  - All FIFO read/write pointers cleared.
  - out_valid = 4'b0000, busy = 0, in_ready = 1.
  - out_data contents don't-care, but driven to 0.
- Reset asserted mid-operation: all buffered beats are discarded immediately. Nothing is replayed after release.
- Per-sink FIFO:
  - Read and write pointers are log2(DEPTH)+1 bits.
  - empty = pointers equal; full = MSBs differ and the remaining bits are equal.
  - Pointers wrap naturally modulo 2*DEPTH.
- in_ready = ~full[in_sel], combinational from in_sel and registered state only. There is no dependence on out_ready, so the block has no ready-to-ready combinational path.
- Push: in_valid && in_ready writes in_data into FIFO[in_sel] and increments that FIFO's write pointer.
- Pop: out_valid[k] && out_ready[k] increments read pointer k. Pops on different sinks are independent and may all occur in the same cycle.
- out_valid[k] = ~empty[k]. out_data[k] = head entry of FIFO k, read combinationally from registered storage.
- Latency: a beat accepted in cycle N is visible on out_valid/out_data of its sink at cycle N+1. There is no same-cycle bypass.
- Simultaneous push and pop on the same sink:
  - Legal whenever not full; occupancy is unchanged.
  - When full, in_ready = 0, so a pop in that cycle does not admit the push. The push is accepted in the following cycle.
- Ordering: beats to the same sink leave in arrival order. There is no ordering guarantee across sinks.
- Source holding rule: once in_valid is high, the source keeps in_data/in_sel stable until accepted. The block does not check this.
- busy = |(~empty[3:0]), registered-state derived.

Optional Feature:
- Macro DEMUX4_STATS_EN.
- When defined:
  - Adds output stat_cnt, 4*32 bits. Field k counts beats popped from sink k.
  - Counters wrap modulo 2^32 and are cleared by resetn.
  - Each increment occurs in the cycle after its pop.
- When undefined: the port and counters are absent. Port list and behaviour are otherwise identical.

Test Plan:
- Reset: hold resetn=0 for 3 cycles with in_valid=1 -> out_valid=0000, busy=0, in_ready=1. No beat is accepted while in reset.
- Routing: send 0xA0,0xA1,0xA2,0xA3 with in_sel=0,1,2,3 and out_ready=1111 -> each value appears one cycle after acceptance on its own sink only, with the other out_valid bits 0.
- Backpressure isolation (DEPTH=2): out_ready[2]=0; send 0x10,0x11,0x12 to sink 2, then 0x20 to sink 1 -> 0x10,0x11 are accepted. 0x12 stalls with in_ready=0. After the source switches to in_sel=1, 0x20 is accepted and delivered. Raising out_ready[2] then drains 0x10,0x11,0x12 in order.
- Full plus simultaneous pop: sink 0 full, out_ready[0]=1, in_valid with in_sel=0 -> in_ready=0 that cycle and 1 the next. Occupancy ends at 2; order is preserved.
- Wrap-around: stream 10 beats 0x00..0x09 to sink 3 with out_ready[3] toggling 1,0 -> all 10 delivered in order, with no loss or duplication across pointer wrap.
- Mid-operation reset: three beats buffered in sinks 0 and 1, pulse resetn low for 1 cycle -> out_valid drops asynchronously, stays 0 after release, busy=0 (with DEMUX4_STATS_EN: stat_cnt=0).
